// File: rtl/spi_flash_seq.sv
// spi_flash_seq: turns flash requests into ordered SPI engine frames
// (WREN, command, RDSR polling) using a held-trigger handshake.
module spi_flash_seq #(
  parameter int POLL_LIMIT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [23:0]   req_addr,
  input  logic [8:0]    req_len,
  input  logic          buf_we,
  input  logic [7:0]    buf_addr,
  input  logic [7:0]    buf_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  output logic          spi_trigger,
  input  logic          spi_busy,
  output logic [8:0]    spi_data_in_count,
  output logic          spi_data_out_count,
  output logic [2079:0] spi_data_in,
  input  logic [63:0]   spi_data_out,
  output logic          spi_quad
);
  typedef enum logic [2:0] {
    INIT, IDLE, WREN, CMD, POLL, RESP
  } state_t;
  typedef enum logic [1:0] {
    P_LOAD, P_ISSUE, P_WAIT
  } phase_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_STAT  = 2'd3;
  localparam logic [19:0] LIMIT = 20'(POLL_LIMIT);

  state_t        state;
  phase_t        phase;
  logic [1:0]    op_q;
  logic [23:0]   addr_q;
  logic [8:0]    len_q;
  logic          err_q;
  logic [7:0]    last_q;
  logic [19:0]   poll_cnt;
  logic [19:0]   poll_nxt;
  logic [7:0]    pbuf [256];
  logic [2047:0] pbytes;
  logic [2079:0] prog_raw;
  logic [8:0]    pad;
  logic [2079:0] f_data;
  logic [8:0]    f_count;
  logic          f_out;
  logic          len_bad;
  logic          unused_out;

  assign spi_quad   = 1'b0;
  assign unused_out = ^spi_data_out[63:8];
  assign len_bad    = (req_len == 9'd0) ||
                      (req_len > 9'd256);
  assign poll_nxt   = (poll_cnt == '1) ? poll_cnt
                                       : poll_cnt + 20'd1;

  always_ff @(posedge clk)
    if (buf_we && req_ready)
      pbuf[buf_addr] <= buf_wdata;

  always_comb begin
    pbytes = '0;
    for (int i = 0; i < 256; i++)
      pbytes[2047-8*i -: 8] = pbuf[i];
  end

  // Full 260-byte frame is MSB-aligned, then shifted down to len+4
  assign pad      = 9'd256 - len_q;
  assign prog_raw = {8'h02, addr_q, pbytes};

  always_comb begin
    f_data      = '0;
    f_data[7:0] = 8'h05;
    f_count     = 9'd1;
    f_out       = 1'b1;
    unique case (1'b1)
      state == WREN: begin
        f_data[7:0] = 8'h06;
        f_out       = 1'b0;
      end
      state == CMD && op_q == OP_READ: begin
        f_data[31:0] = {8'h03, addr_q};
        f_count      = 9'd4;
      end
      state == CMD && op_q == OP_ERASE: begin
        f_data[31:0] = {8'hD8, addr_q};
        f_count      = 9'd4;
        f_out        = 1'b0;
      end
      state == CMD && op_q == OP_PROG: begin
        f_data  = prog_raw >> {pad, 3'b000};
        f_count = len_q + 9'd4;
        f_out   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= INIT;
      phase              <= P_LOAD;
      req_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= 8'h00;
      rsp_err            <= 1'b0;
      spi_trigger        <= 1'b0;
      spi_data_in_count  <= 9'd0;
      spi_data_out_count <= 1'b0;
      spi_data_in        <= '0;
      op_q               <= OP_READ;
      addr_q             <= 24'h0;
      len_q              <= 9'd0;
      err_q              <= 1'b0;
      last_q             <= 8'h00;
      poll_cnt           <= 20'd0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        INIT:
          if (!spi_busy) state <= IDLE;
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            addr_q    <= req_addr;
            len_q     <= req_len;
            poll_cnt  <= 20'd0;
            err_q     <= 1'b0;
            phase     <= P_LOAD;
            if (req_op == OP_PROG && len_bad) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (req_op == OP_PROG ||
                         req_op == OP_ERASE)
              state <= WREN;
            else
              state <= CMD;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_data  <= last_q;
          state     <= IDLE;
        end
        default:
          unique case (phase)
            P_LOAD: begin
              spi_data_in        <= f_data;
              spi_data_in_count  <= f_count;
              spi_data_out_count <= f_out;
              spi_trigger        <= 1'b1;
              phase              <= P_ISSUE;
            end
            P_ISSUE:
              if (spi_busy) begin
                spi_trigger <= 1'b0;
                phase       <= P_WAIT;
              end
            default:
              if (!spi_busy) begin
                last_q <= spi_data_out[7:0];
                phase  <= P_LOAD;
                case (state)
                  WREN: state <= CMD;
                  CMD:
                    if (op_q == OP_READ ||
                        op_q == OP_STAT)
                      state <= RESP;
                    else
                      state <= POLL;
                  default: begin
                    poll_cnt <= poll_nxt;
                    if (!spi_data_out[0])
                      state <= RESP;
                    else if (poll_nxt >= LIMIT) begin
                      err_q <= 1'b1;
                      state <= RESP;
                    end
                  end
                endcase
              end
          endcase
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: directed checks of spi_flash_seq against a
// simple SPI engine model that logs every frame it accepts.
module tb_spi_flash_seq;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [23:0]   req_addr = 24'h0;
  logic [8:0]    req_len = 9'd0;
  logic          buf_we = 1'b0;
  logic [7:0]    buf_addr = 8'h0;
  logic [7:0]    buf_wdata = 8'h0;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic          spi_trigger;
  logic          spi_busy = 1'b1;
  logic [8:0]    spi_data_in_count;
  logic          spi_data_out_count;
  logic [2079:0] spi_data_in;
  logic [63:0]   spi_data_out = 64'h0;
  logic          spi_quad;

  always #5 clk = ~clk;

  spi_flash_seq #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_len(req_len),
    .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .spi_trigger(spi_trigger), .spi_busy(spi_busy),
    .spi_data_in_count(spi_data_in_count),
    .spi_data_out_count(spi_data_out_count),
    .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out),
    .spi_quad(spi_quad)
  );

  int checks = 0;
  int errors = 0;
  int busy_cnt = 10;
  bit tog = 1'b0;
  logic [7:0]    rq[$];
  logic [2079:0] fq_data[$];
  logic [8:0]    fq_cnt[$];
  logic          fq_out[$];

  // Engine model: samples trigger only on alternate cycles
  always @(negedge clk) begin
    if (reset) begin
      spi_busy = 1'b1;
      busy_cnt = 10;
    end else begin
      tog = ~tog;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) spi_busy = 1'b0;
      end else if (spi_trigger && tog) begin
        fq_data.push_back(spi_data_in);
        fq_cnt.push_back(spi_data_in_count);
        fq_out.push_back(spi_data_out_count);
        spi_data_out = {56'hA5A55A5A0F0FF0, 8'h00};
        if (rq.size() > 0)
          spi_data_out[7:0] = rq.pop_front();
        spi_busy = 1'b1;
        busy_cnt = 3;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int idx,
                           input logic [8:0] cnt,
                           input logic o,
                           input logic [2079:0] d);
    logic [8:0]    gc;
    logic          go;
    logic [2079:0] gd;
    gc = 'x; go = 1'bx; gd = 'x;
    if (idx < fq_data.size()) begin
      gc = fq_cnt[idx]; go = fq_out[idx]; gd = fq_data[idx];
    end
    checks++;
    assert (gc === cnt && go === o && gd === d) else begin
      errors++;
      $error("FAIL %s got cnt=%0d out=%0d lo=%0h exp cnt=%0d out=%0d lo=%0h",
             tag, gc, go, gd[63:0], cnt, o, d[63:0]);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  task automatic send_req(input string tag, input logic [1:0] op,
                          input logic [23:0] a,
                          input logic [8:0] l);
    wait_ready(tag);
    req_valid = 1'b1; req_op = op;
    req_addr = a; req_len = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_buf(input logic [7:0] a, input logic [7:0] d);
    wait_ready("wrbuf");
    buf_we = 1'b1; buf_addr = a; buf_wdata = d;
    @(posedge clk); #1;
    buf_we = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input bit cd,
                          input logic [7:0] ed,
                          input logic ee);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    if (cd) chk({tag, "_data"}, 64'(rsp_data), 64'(ed));
    chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit low_ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_trigger", 64'(spi_trigger), 64'd0);
    chk("rst_cnt", 64'(spi_data_in_count), 64'd0);
    chk("rst_outcnt", 64'(spi_data_out_count), 64'd0);
    chk("rst_data_in", 64'(|spi_data_in), 64'd0);
    chk("rst_quad", 64'(spi_quad), 64'd0);
    reset = 1'b0;

    low_ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (req_ready) low_ok = 1'b0;
    end
    chk("init_hold", 64'(low_ok), 64'd1);
    wait_ready("init");
    chk("init_busy_low", 64'(spi_busy), 64'd0);

    base = fq_data.size();
    rq.push_back(8'hA5);
    send_req("stat", 2'd3, 24'h0, 9'd0);
    wait_rsp("stat", 1'b1, 8'hA5, 1'b0);
    chk("stat_nf", 64'(fq_data.size() - base), 64'd1);
    chk_frame("stat_f", base, 9'd1, 1'b1, 2080'h05);

    base = fq_data.size();
    rq.push_back(8'h3C);
    send_req("read", 2'd0, 24'h123456, 9'd0);
    wait_rsp("read", 1'b1, 8'h3C, 1'b0);
    chk("read_nf", 64'(fq_data.size() - base), 64'd1);
    chk_frame("read_f", base, 9'd4, 1'b1, 2080'h03123456);

    wr_buf(8'd0, 8'h11);
    wr_buf(8'd1, 8'h22);
    chk("read_hold", 64'(rsp_data), 64'h3C);
    base = fq_data.size();
    rq.delete();
    rq.push_back(8'h00); rq.push_back(8'h00);
    rq.push_back(8'h01); rq.push_back(8'h01);
    rq.push_back(8'h01); rq.push_back(8'h00);
    send_req("prog", 2'd1, 24'h000100, 9'd2);
    buf_we = 1'b1; buf_addr = 8'd0; buf_wdata = 8'hFF;
    @(posedge clk); #1;
    buf_we = 1'b0;
    wait_rsp("prog", 1'b1, 8'h00, 1'b0);
    chk("prog_nf", 64'(fq_data.size() - base), 64'd6);
    chk_frame("prog_wren", base, 9'd1, 1'b0, 2080'h06);
    chk_frame("prog_cmd", base + 1, 9'd6, 1'b0,
              2080'h020001001122);
    for (int i = 2; i < 6; i++)
      chk_frame("prog_poll", base + i, 9'd1, 1'b1, 2080'h05);

    base = fq_data.size();
    rq.delete();
    rq.push_back(8'h00); rq.push_back(8'h00);
    repeat (6) rq.push_back(8'h01);
    send_req("erase", 2'd2, 24'hABCDEF, 9'd0);
    wait_rsp("erase", 1'b0, 8'h00, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("erase_nf", 64'(fq_data.size() - base), 64'd6);
    chk_frame("erase_wren", base, 9'd1, 1'b0, 2080'h06);
    chk_frame("erase_cmd", base + 1, 9'd4, 1'b0,
              2080'hD8ABCDEF);
    for (int i = 2; i < 6; i++)
      chk_frame("erase_poll", base + i, 9'd1, 1'b1, 2080'h05);
    rq.delete();

    base = fq_data.size();
    send_req("len0", 2'd1, 24'h000200, 9'd0);
    chk("len0_c1", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("len0_c2", 64'(rsp_valid), 64'd1);
    chk("len0_err", 64'(rsp_err), 64'd1);
    chk("len0_trig", 64'(spi_trigger), 64'd0);

    send_req("len257", 2'd1, 24'h000200, 9'd257);
    chk("len257_c1", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("len257_c2", 64'(rsp_valid), 64'd1);
    chk("len257_err", 64'(rsp_err), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("len_nf", 64'(fq_data.size() - base), 64'd0);
    chk("len_trig", 64'(spi_trigger), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
